// File: rtl/reg_ctrl_pkg.sv
// Shared op encodings and FSM state type for the register write controller.
package reg_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_CLR  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COMMIT = 2'b01,
        DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/reg_inc.sv
// WIDTH-bit incrementer with carry-out; only exists when REG_WRITE_INC_EN is defined,
// so a build without INC carries no incrementer at all.
`ifdef REG_WRITE_INC_EN
module reg_inc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

endmodule
`endif

// File: rtl/reg_write_ctrl.sv
// Three-state write controller for two WIDTH-bit registers (LOAD/INC/CLR).
// Define REG_WRITE_INC_EN to enable INC; otherwise INC is rejected like the reserved op.
module reg_write_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus,
    input  logic             wr_req,
    input  logic             reg_addr,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] R2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             wrap
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] stage_data_r;
    logic             stage_addr_r;
    op_e              stage_op_r;
    logic [WIDTH-1:0] r1_r;
    logic [WIDTH-1:0] r2_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             capture_s;
    logic             commit_s;
    logic             write_s;
    logic             reject_s;
    logic [WIDTH-1:0] new_val_s;

`ifdef REG_WRITE_INC_EN
    logic [WIDTH-1:0] target_old_s;
    logic [WIDTH-1:0] inc_sum_s;
    logic             inc_carry_s;
    logic             wrap_s;
    logic             wrap_r;

    assign target_old_s = stage_addr_r ? r2_r : r1_r;

    reg_inc #(.WIDTH(WIDTH)) u_inc (
        .a     (target_old_s),
        .sum   (inc_sum_s),
        .carry (inc_carry_s)
    );
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; requests outside IDLE are deliberately ignored
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (wr_req) begin
                    state_nxt_s = COMMIT;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COMMIT: begin
                state_nxt_s = DONE;
                commit_s    = 1'b1;
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operation decode from the staged request
    always_comb begin
        new_val_s = stage_data_r;
        write_s   = 1'b0;
        reject_s  = 1'b0;
`ifdef REG_WRITE_INC_EN
        wrap_s    = 1'b0;
`endif
        case (stage_op_r)
            OP_LOAD: begin
                new_val_s = stage_data_r;
                write_s   = 1'b1;
            end
            OP_CLR: begin
                new_val_s = {WIDTH{1'b0}};
                write_s   = 1'b1;
            end
`ifdef REG_WRITE_INC_EN
            OP_INC: begin
                new_val_s = inc_sum_s;
                write_s   = 1'b1;
                wrap_s    = inc_carry_s;
            end
`else
            OP_INC: begin
                reject_s = 1'b1;
            end
`endif
            OP_RSVD: begin
                reject_s = 1'b1;
            end
            default: begin
                reject_s = 1'b1;
            end
        endcase
    end

    // Stage register: frozen from E0 so later bus/op/addr changes cannot leak in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_data_r <= {WIDTH{1'b0}};
            stage_addr_r <= 1'b0;
            stage_op_r   <= OP_LOAD;
        end else if (capture_s) begin
            stage_data_r <= bus;
            stage_addr_r <= reg_addr;
            stage_op_r   <= op_e'(op);
        end
    end

    // Target registers change only at the COMMIT edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_r <= RST_VAL;
            r2_r <= RST_VAL;
        end else if (commit_s && write_s) begin
            if (stage_addr_r) begin
                r2_r <= new_val_s;
            end else begin
                r1_r <= new_val_s;
            end
        end
    end

    // Status flops; done/err land in the DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= commit_s;
            err_r  <= commit_s & reject_s;
        end
    end

`ifdef REG_WRITE_INC_EN
    // Wrap flag pulses alongside done when INC rolled over
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= commit_s & wrap_s;
        end
    end

    assign wrap = wrap_r;
`else
    assign wrap = 1'b0;
`endif

    assign R1   = r1_r;
    assign R2   = r2_r;
    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Self-checking bench for reg_write_ctrl: directed scenarios plus random traffic
// against a transaction-level model (accept when free, result one edge later, 3-edge spacing).
module tb_reg_write_ctrl;

    localparam int WIDTH = 8;
`ifdef REG_WRITE_INC_EN
    localparam bit INC_EN = 1'b1;
`else
    localparam bit INC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] bus;
    logic             wr_req;
    logic             reg_addr;
    logic [1:0]       op;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             busy;
    logic             done;
    logic             err;
    logic             wrap;

    always #5 clk = ~clk;

    reg_write_ctrl #(.WIDTH(WIDTH), .RST_VAL(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .wr_req   (wr_req),
        .reg_addr (reg_addr),
        .op       (op),
        .R1       (r1),
        .R2       (r2),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wrap     (wrap)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: registers as plain integers, timing as edge numbers
    int  cyc      = 0;
    int  free_at  = 0;
    bit  pend     = 1'b0;
    int  pend_at  = 0;
    int  pend_op  = 0;
    int  pend_adr = 0;
    int  pend_dat = 0;
    int  mreg [2];
    bit  m_done, m_err, m_wrap, m_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mreg[0] = 0;
        mreg[1] = 0;
        pend    = 1'b0;
        free_at = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_wrap  = 1'b0;
        m_busy  = 1'b0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_wrap = 1'b0;
        if (pend && cyc == pend_at) begin
            m_done = 1'b1;
            pend   = 1'b0;
            if (pend_op == 0) begin
                mreg[pend_adr] = pend_dat;
            end else if (pend_op == 2) begin
                mreg[pend_adr] = 0;
            end else if (pend_op == 1 && INC_EN) begin
                m_wrap = (mreg[pend_adr] == 255);
                mreg[pend_adr] = (mreg[pend_adr] + 1) % 256;
            end else begin
                m_err = 1'b1;
            end
        end
        if (cyc >= free_at && wr_req) begin
            pend     = 1'b1;
            pend_at  = cyc + 1;
            free_at  = cyc + 3;
            pend_op  = int'(op);
            pend_adr = int'(reg_addr);
            pend_dat = int'(bus);
        end
        m_busy = (cyc < free_at - 1);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".R1"},   r1,   mreg[0]);
        chk({tag, ".R2"},   r2,   mreg[1]);
        chk({tag, ".busy"}, busy, m_busy);
        chk({tag, ".done"}, done, m_done);
        chk({tag, ".err"},  err,  m_err);
        chk({tag, ".wrap"}, wrap, m_wrap);
    endtask

    task automatic step(input logic w, input logic a, input logic [1:0] o, input logic [7:0] d);
        wr_req   = w;
        reg_addr = a;
        op       = o;
        bus      = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all("step");
        cyc++;
    endtask

    // asynchronous reset pulse placed mid-cycle, held across one rising edge
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_now");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int dones;
        rst      = 1'b1;
        wr_req   = 1'b0;
        reg_addr = 1'b0;
        op       = 2'b00;
        bus      = 8'h00;
        model_reset();
        #12;
        check_all("por");
        rst = 1'b0;

        // reset clears loaded values immediately
        step(1'b1, 1'b0, 2'b00, 8'h5A);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b1, 1'b1, 2'b00, 8'hA5);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("pre_rst_r1", r1, 8'h5A);
        chk("pre_rst_r2", r2, 8'hA5);
        pulse_reset();
        chk("rst_r1", r1, 8'h00);
        chk("rst_r2", r2, 8'h00);
        chk("rst_busy", busy, 1'b0);

        // LOAD with bus changing after E0
        step(1'b1, 1'b0, 2'b00, 8'h3C);
        chk("ld_busy_e0", busy, 1'b1);
        step(1'b0, 1'b1, 2'b10, 8'hFF);
        chk("ld_r1", r1, 8'h3C);
        chk("ld_r2", r2, 8'h00);
        chk("ld_done", done, 1'b1);
        step(1'b0, 1'b0, 2'b00, 8'hFF);
        chk("ld_done_end", done, 1'b0);
        chk("ld_busy_end", busy, 1'b0);

        // INC wrap on R2
        step(1'b1, 1'b1, 2'b00, 8'hFF);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b1, 1'b1, 2'b01, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("inc_r2",   r2,   INC_EN ? 8'h00 : 8'hFF);
        chk("inc_wrap", wrap, INC_EN);
        chk("inc_err",  err,  !INC_EN);
        step(1'b0, 1'b0, 2'b00, 8'h00);

        // reserved op
        step(1'b1, 1'b0, 2'b00, 8'h12);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b1, 1'b0, 2'b11, 8'h99);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("rsv_r1",   r1,   8'h12);
        chk("rsv_err",  err,  1'b1);
        chk("rsv_done", done, 1'b1);
        step(1'b0, 1'b0, 2'b00, 8'h00);

        // wr_req held six cycles: accepts at 0 and 3
        step(1'b1, 1'b0, 2'b10, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 2'b00, 8'h01);
            chk("burst_done_pos", done, (i == 1 || i == 4));
            if (done) dones++;
        end
        step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("burst_writes", dones, 2);
        chk("burst_r1", r1, 8'h01);

        // reset during COMMIT aborts the write
        step(1'b1, 1'b0, 2'b00, 8'h77);
        pulse_reset();
        chk("abort_r1",   r1,   8'h00);
        chk("abort_done", done, 1'b0);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("abort_nodone", done, 1'b0);
        step(1'b1, 1'b0, 2'b00, 8'h05);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("post_rst_r1",   r1,   8'h05);
        chk("post_rst_done", done, 1'b1);
        step(1'b0, 1'b0, 2'b00, 8'h00);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step($urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom), d);
            if ($urandom_range(0, 79) == 0) pulse_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_write_ctrl.md
REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of the bus and of R1/R2.
REQ-002 The block SHALL have parameter RST_VAL, default 0, giving the reset value of R1 and R2.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: the asynchronous, active-high reset.
REQ-006 Port bus, input, WIDTH: the write data source.
REQ-007 Port wr_req, input, 1: level write request.
REQ-008 Port reg_addr, input, 1: the target register, 0 = R1, 1 = R2.
REQ-009 Port op, input, 2: the operation, 00 LOAD, 01 INC, 10 CLR, 11 reserved.
REQ-010 Ports R1 and R2, output, WIDTH each: the register contents, driven directly from flops.
REQ-011 Port busy, output, 1: high in every state other than IDLE.
REQ-012 Port done, output, 1: a one-cycle completion pulse.
REQ-013 Port err, output, 1: a one-cycle pulse with done when the operation was rejected.
REQ-014 Port wrap, output, 1: a one-cycle pulse with done when an INC wrapped from all-ones to zero.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, COMMIT and DONE.
REQ-016 IDLE with wr_req=1 at edge E0: the block SHALL capture bus, reg_addr and op into a stage register and go to COMMIT.
REQ-017 IDLE with wr_req=0: the FSM SHALL stay in IDLE and R1/R2 SHALL hold.
REQ-018 COMMIT at edge E1: the block SHALL update the target register from the stage register, go to DONE and assert done for exactly the DONE cycle.
REQ-019 DONE at edge E2: the FSM SHALL return to IDLE unconditionally, giving a maximum rate of one write per 3 cycles.
REQ-020 LOAD SHALL write the staged bus value to the target register.
REQ-021 CLR SHALL write 0 to the target register.
REQ-022 INC SHALL write target+1 modulo 2^WIDTH; when the old value was all-ones the result SHALL be 0 and wrap SHALL pulse with done.
REQ-023 Reserved op 11 SHALL leave both registers unchanged and SHALL pulse err with done.
REQ-024 Only the addressed register SHALL change; the other SHALL hold.
REQ-025 bus, reg_addr and op changes after E0 SHALL have no effect on the operation in flight.
REQ-026 wr_req seen in COMMIT or DONE SHALL be ignored; a request still high in IDLE after DONE SHALL be accepted as a new write, so the requester drops wr_req on done.
REQ-027 R1 and R2 SHALL show their old values up to E1 and the new value from E1 on, so an external read mux sees no intermediate value.

Reset
REQ-028 On rst=1, independent of clk, the block SHALL immediately set R1=R2=RST_VAL, the FSM to IDLE, busy=done=err=wrap=0 and the stage register to 0.
REQ-029 A reset in COMMIT or DONE SHALL abort the operation: no register write and no done pulse.
REQ-030 The first request SHALL be accepted on the first rising edge after rst deasserts with wr_req=1.

Configuration
REQ-031 With macro REG_WRITE_INC_EN defined, INC SHALL behave as in REQ-022.
REQ-032 With REG_WRITE_INC_EN undefined, INC SHALL be treated as reserved (REQ-023), wrap SHALL be tied to 0 and no incrementer logic SHALL be synthesised.

Structure
REQ-033 Package reg_ctrl_pkg SHALL hold the op encodings (OP_LOAD, OP_INC, OP_CLR, OP_RSVD) and the FSM state enum.
REQ-034 The incrementer SHALL be the sub-module reg_inc (WIDTH-parameterised, outputs sum and carry-out used for wrap), instantiated only under REG_WRITE_INC_EN.

Verification
REQ-035 The bench SHALL check: reset with R1=0x5A, R2=0xA5 -> both 0x00 immediately, busy=0.
REQ-036 The bench SHALL check: wr_req, reg_addr=0, op=LOAD, bus=0x3C at E0, bus changed to 0xFF at E0+1 -> R1=0x3C at E1, R2 unchanged, done high for one cycle at E1..E2, busy high E0..E2.
REQ-037 The bench SHALL check: R2=0xFF, INC on addr 1 -> R2=0x00 and wrap=1 with done; with REG_WRITE_INC_EN undefined -> R2 stays 0xFF and err=1.
REQ-038 The bench SHALL check: op=11 on addr 0 with R1=0x12 -> R1 stays 0x12 and err pulses with done.
REQ-039 The bench SHALL check: wr_req held high for 6 cycles with LOAD 0x01 -> exactly two writes, accepted at cycles 0 and 3.
REQ-040 The bench SHALL check: rst asserted in COMMIT of a LOAD 0x77 -> R1=RST_VAL, no done pulse, then a normal LOAD completes after reset.
